// File: rtl/audio_pkg.sv
// audio_pkg: shared state type, frame-format constants and width helper for audio_dac_stream.
package audio_pkg;
    typedef enum logic [1:0] {IDLE, WAIT_FRAME, LEFT, RIGHT} dac_state_t;
    localparam int MODE_I2S = 0;
    localparam int MODE_LJ = 1;
    function automatic int fill_w(input int depth);
        return $clog2(depth) + 1;
    endfunction
endpackage

// File: rtl/audio_dac_stream_if.sv
// audio_dac_stream_if: valid/ready sample stream feeding the DAC FIFO.
interface audio_dac_stream_if #(parameter int SAMPLE_W = 24);
    logic [SAMPLE_W-1:0] in_data;
    logic in_valid;
    logic in_ready;
    modport master (output in_data, in_valid, input in_ready);
    modport slave (input in_data, in_valid, output in_ready);
endinterface

// File: rtl/audio_sync_fifo.sv
// audio_sync_fifo: single-clock sample FIFO with occupancy count, registered ready and synchronous flush.
module audio_sync_fifo
    import audio_pkg::*;
#(
    parameter int W = 24,
    parameter int DEPTH = 64,
    localparam int CW = fill_w(DEPTH),
    localparam int AW = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          flush,
    input  logic          push,
    input  logic          pop,
    input  logic [W-1:0]  din,
    output logic [W-1:0]  dout,
    output logic [CW-1:0] count,
    output logic          ready
);
    logic [W-1:0] mem [DEPTH];
    logic [AW-1:0] wp, rp;
    logic [CW-1:0] count_n;
    logic do_push, do_pop;
    always_comb begin
        do_push = push && ready && !flush;
        do_pop = pop && count != '0 && !flush;
        count_n = count + CW'(do_push) - CW'(do_pop);
    end
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n || flush) begin
            wp <= '0;
            rp <= '0;
            count <= '0;
            ready <= 1'b1;
        end else begin
            wp <= wp + AW'(do_push);
            rp <= rp + AW'(do_pop);
            count <= count_n;
            ready <= count_n != CW'(DEPTH);
        end
    always_ff @(posedge clk)
        if (do_push) mem[wp] <= din;
    assign dout = mem[rp];
endmodule

// File: rtl/audio_dac_stream.sv
// audio_dac_stream: buffers stereo PCM in a FIFO and serialises it onto dacdat, following codec bclk/daclrck.
// Define AUDIO_DAC_STREAM_UNDERRUN_CNT_EN to add the saturating underrun_count output.
module audio_dac_stream
    import audio_pkg::*;
#(
    parameter int SAMPLE_W = 24,
    parameter int FIFO_DEPTH = 64,
    parameter int MODE = MODE_I2S,
    parameter int LOW_WATER = 16,
    localparam int CW = fill_w(FIFO_DEPTH)
) (
    input  logic           clk_clk,
    input  logic           reset_reset_n,
    audio_dac_stream_if.slave stream,
    input  logic           enable,
    input  logic           flush,
    input  logic           bclk,
    input  logic           daclrck,
    output logic           dacdat,
    output logic           irq,
    output logic [CW-1:0]  fill_level,
    output logic           underrun
`ifdef AUDIO_DAC_STREAM_UNDERRUN_CNT_EN
    ,
    output logic [15:0]    underrun_count
`endif
);
    localparam int BW = $clog2(SAMPLE_W + 1);
    localparam bit LJ = MODE == MODE_LJ;
    dac_state_t state, state_n;
    logic [2:0] bclk_s, lrck_s;
    logic bclk_fall, lrck_fall, lrck_rise;
    logic [SAMPLE_W-1:0] fifo_dout, load_word, sr;
    logic [BW-1:0] bit_cnt;
    logic pop, load, zero_fill, zf_n, uflow;

    audio_sync_fifo #(.W(SAMPLE_W), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk(clk_clk), .rst_n(reset_reset_n), .flush, .push(stream.in_valid), .pop,
        .din(stream.in_data), .dout(fifo_dout), .count(fill_level), .ready(stream.in_ready)
    );

    // two synchroniser flops, third flop is the edge-detect history
    always_ff @(posedge clk_clk or negedge reset_reset_n)
        if (!reset_reset_n) begin
            bclk_s <= '0;
            lrck_s <= '0;
        end else begin
            bclk_s <= {bclk_s[1:0], bclk};
            lrck_s <= {lrck_s[1:0], daclrck};
        end
    assign bclk_fall = bclk_s[2] && !bclk_s[1];
    assign lrck_fall = lrck_s[2] && !lrck_s[1];
    assign lrck_rise = !lrck_s[2] && lrck_s[1];

    always_ff @(posedge clk_clk or negedge reset_reset_n)
        if (!reset_reset_n) state <= IDLE;
        else state <= state_n;

    // a frame is only started with both words present, so L/R pairing never slips
    always_comb begin
        state_n = state;
        pop = 1'b0;
        load = 1'b0;
        load_word = '0;
        zf_n = zero_fill;
        uflow = 1'b0;
        case (state)
            IDLE: state_n = enable ? WAIT_FRAME : IDLE;
            WAIT_FRAME, RIGHT:
                if (lrck_fall) begin
                    if (!enable) state_n = IDLE;
                    else begin
                        state_n = LEFT;
                        load = 1'b1;
                        zf_n = fill_level < CW'(2);
                        uflow = zf_n;
                        pop = !zf_n;
                        load_word = zf_n ? '0 : fifo_dout;
                    end
                end
            LEFT:
                if (lrck_rise) begin
                    state_n = RIGHT;
                    load = 1'b1;
                    pop = !zero_fill && fill_level != '0;
                    load_word = pop ? fifo_dout : '0;
                end
        endcase
    end

    always_ff @(posedge clk_clk or negedge reset_reset_n)
        if (!reset_reset_n) begin
            zero_fill <= 1'b0;
            sr <= '0;
            bit_cnt <= '0;
            dacdat <= 1'b0;
            underrun <= 1'b0;
            irq <= 1'b0;
        end else begin
            zero_fill <= zf_n;
            underrun <= uflow;
            irq <= enable && fill_level <= CW'(LOW_WATER);
            if (state_n == IDLE) begin
                sr <= '0;
                bit_cnt <= '0;
                dacdat <= 1'b0;
            end else if (load) begin
                sr <= LJ ? load_word << 1 : load_word;
                bit_cnt <= BW'(LJ ? SAMPLE_W - 1 : SAMPLE_W);
                dacdat <= LJ && load_word[SAMPLE_W-1];
            end else if (bclk_fall) begin
                dacdat <= bit_cnt != '0 && sr[SAMPLE_W-1];
                sr <= sr << 1;
                bit_cnt <= bit_cnt - BW'(bit_cnt != '0);
            end
        end

`ifdef AUDIO_DAC_STREAM_UNDERRUN_CNT_EN
    always_ff @(posedge clk_clk or negedge reset_reset_n)
        if (!reset_reset_n) underrun_count <= '0;
        else if (flush) underrun_count <= '0;
        else if (underrun && underrun_count != 16'hFFFF) underrun_count <= underrun_count + 16'd1;
`endif
endmodule

// File: tb/tb_audio_dac_stream.sv
// tb_audio_dac_stream: I2S and left-justified instances share random stimulus; a codec-side receiver
// rebuilds each slot word and compares it with a queue model of the FIFO and frame rules.
`timescale 1ns/1ps
module tb_audio_dac_stream;
    import audio_pkg::*;
    localparam int SW = 24, DEPTH = 64, LW = 16, SLOT = 32;
    localparam int FW = fill_w(DEPTH);

    logic clk_clk = 1'b0, reset_reset_n = 1'b0, enable = 1'b0, flush = 1'b0, bclk = 1'b1, daclrck = 1'b1;
    logic dacdat0, dacdat1, irq0, irq1, underrun0, underrun1;
    logic [FW-1:0] fill0, fill1;
    audio_dac_stream_if #(.SAMPLE_W(SW)) s0 ();
    audio_dac_stream_if #(.SAMPLE_W(SW)) s1 ();
`ifdef AUDIO_DAC_STREAM_UNDERRUN_CNT_EN
    logic [15:0] ucnt0, ucnt1;
`endif

    audio_dac_stream #(.SAMPLE_W(SW), .FIFO_DEPTH(DEPTH), .MODE(MODE_I2S), .LOW_WATER(LW)) dut0 (
        .clk_clk, .reset_reset_n, .stream(s0), .enable, .flush, .bclk, .daclrck,
        .dacdat(dacdat0), .irq(irq0), .fill_level(fill0), .underrun(underrun0)
`ifdef AUDIO_DAC_STREAM_UNDERRUN_CNT_EN
        , .underrun_count(ucnt0)
`endif
    );
    audio_dac_stream #(.SAMPLE_W(SW), .FIFO_DEPTH(DEPTH), .MODE(MODE_LJ), .LOW_WATER(LW)) dut1 (
        .clk_clk, .reset_reset_n, .stream(s1), .enable, .flush, .bclk, .daclrck,
        .dacdat(dacdat1), .irq(irq1), .fill_level(fill1), .underrun(underrun1)
`ifdef AUDIO_DAC_STREAM_UNDERRUN_CNT_EN
        , .underrun_count(ucnt1)
`endif
    );

    always #5 clk_clk = ~clk_clk;

    int n_checks = 0, n_errors = 0;
    logic [SW-1:0] q[$];
    logic [SW-1:0] exp_word = '0, rx0 = '0, rx1 = '0;
    logic rpend = 1'b0, tail0 = 1'b0, tail1 = 1'b0;
    int exp_urun = 0, urun0 = 0, urun1 = 0, exp_ucnt = 0, slot_pos = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    always @(posedge clk_clk) begin
        if (underrun0 === 1'b1) urun0++;
        if (underrun1 === 1'b1) urun1++;
    end

    // end of a slot: judge what the codec received, then apply the frame rules for the next slot
    task automatic slot_edge();
        check("word_i2s", rx0, exp_word);
        check("word_lj", rx1, exp_word);
        check("tail_i2s", tail0, 1'b0);
        check("tail_lj", tail1, 1'b0);
        check("underruns_i2s", urun0, exp_urun);
        check("underruns_lj", urun1, exp_urun);
`ifdef AUDIO_DAC_STREAM_UNDERRUN_CNT_EN
        check("ucnt_i2s", ucnt0, exp_ucnt);
        check("ucnt_lj", ucnt1, exp_ucnt);
`endif
        daclrck = ~daclrck;
        rx0 = '0; rx1 = '0; tail0 = 1'b0; tail1 = 1'b0;
        if (!daclrck) begin
            rpend = 1'b0;
            if (!enable) exp_word = '0;
            else if (q.size() >= 2) begin
                exp_word = q.pop_front();
                rpend = 1'b1;
            end else begin
                exp_word = '0;
                exp_urun++;
                if (exp_ucnt < 65535) exp_ucnt++;
            end
        end else begin
            exp_word = (rpend && q.size() > 0) ? q.pop_front() : '0;
            rpend = 1'b0;
        end
    endtask

    // codec samples on bclk rise: I2S MSB one bit after the LRCK edge, LJ MSB at the edge
    task automatic sample(input int s);
        if (s >= 1 && s <= SW) rx0 = {rx0[SW-2:0], dacdat0};
        else if (s > SW) tail0 = tail0 | dacdat0;
        if (s < SW) rx1 = {rx1[SW-2:0], dacdat1};
        else tail1 = tail1 | dacdat1;
    endtask

    initial begin
        #8;
        forever
            for (int s = 0; s < SLOT; s++) begin
                #40 bclk = 1'b0;
                slot_pos = s;
                if (s == 0) slot_edge();
                #40 bclk = 1'b1;
                sample(s);
            end
    end

    task automatic wait_pos(input int p, input logic lr);
        do @(posedge bclk); while (!(slot_pos == p && daclrck == lr));
    endtask

    task automatic push_word(input logic [SW-1:0] w);
        @(negedge clk_clk);
        check("in_ready_i2s", s0.in_ready, q.size() < DEPTH);
        check("in_ready_lj", s1.in_ready, q.size() < DEPTH);
        s0.in_data = w; s0.in_valid = 1'b1;
        s1.in_data = w; s1.in_valid = 1'b1;
        if (q.size() < DEPTH) q.push_back(w);
    endtask

    task automatic push_end();
        @(negedge clk_clk);
        s0.in_valid = 1'b0;
        s1.in_valid = 1'b0;
    endtask

    task automatic check_status();
        repeat (3) @(negedge clk_clk);
        check("fill_i2s", fill0, q.size());
        check("fill_lj", fill1, q.size());
        check("irq_i2s", irq0, enable && q.size() <= LW);
        check("irq_lj", irq1, enable && q.size() <= LW);
    endtask

    task automatic do_flush();
        @(negedge clk_clk);
        flush = 1'b1;
        @(negedge clk_clk);
        flush = 1'b0;
        q.delete();
        exp_ucnt = 0;
        check("flush_fill_i2s", fill0, 0);
        check("flush_fill_lj", fill1, 0);
`ifdef AUDIO_DAC_STREAM_UNDERRUN_CNT_EN
        check("flush_ucnt", ucnt0, 0);
`endif
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        s0.in_valid = 1'b0; s0.in_data = '0;
        s1.in_valid = 1'b0; s1.in_data = '0;
        #22;
        check("rst_dacdat", dacdat0, 1'b0);
        check("rst_irq", irq0, 1'b0);
        check("rst_underrun", underrun1, 1'b0);
        check("rst_fill", fill0, 0);
        check("rst_ready", s0.in_ready, 1'b1);
        #10 reset_reset_n = 1'b1;
        check_status();
        // enable with empty FIFO: next frame underruns and plays silence
        wait_pos(4, 1'b1);
        enable = 1'b1;
        check_status();
        wait_pos(4, 1'b1);
        check("first_underrun", urun0, 1);
        push_word(24'hA5A5A5);
        push_word(24'h5A5A5A);
        push_end();
        check_status();
        wait_pos(4, 1'b0);
        check_status();
        wait_pos(4, 1'b1);
        check_status();
        // fill to the brim; one extra word must be refused
        for (int i = 0; i < DEPTH + 1; i++) push_word(SW'($urandom));
        push_end();
        check_status();
        check("full_fill", fill0, DEPTH);
        check("full_ready", s0.in_ready, 1'b0);
        do_flush();
        // a lone word is held back until its partner arrives
        push_word(SW'($urandom));
        push_end();
        wait_pos(4, 1'b0);
        check_status();
        push_word(SW'($urandom));
        push_end();
        wait_pos(4, 1'b1);
        wait_pos(4, 1'b0);
        check_status();
        // flush while the right word is on the wire
        wait_pos(4, 1'b1);
        for (int i = 0; i < 10; i++) push_word(SW'($urandom));
        push_end();
        wait_pos(8, 1'b1);
        check_status();
        do_flush();
        wait_pos(4, 1'b0);
        check_status();
        for (int it = 0; it < 30; it++) begin
            wait_pos($urandom_range(2, 6), 1'b1);
            case ($urandom_range(0, 7))
                0: enable = ~enable;
                1: do_flush();
                default: for (int k = $urandom_range(0, 5); k > 0; k--) push_word(SW'($urandom));
            endcase
            push_end();
            check_status();
        end
        wait_pos(4, 1'b1);
        wait_pos(4, 1'b1);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
